// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - CRC helper functions and standard CRC presets
package crc_pkg;

    // CRC-8/SMBUS preset
    localparam logic [63:0] CRC8_SMBUS_POLY    = 64'h07;
    localparam logic [63:0] CRC8_SMBUS_INIT    = 64'h00;
    localparam logic [63:0] CRC8_SMBUS_XOR_OUT = 64'h00;
    localparam bit          CRC8_SMBUS_REFIN   = 1'b0;
    localparam bit          CRC8_SMBUS_REFOUT  = 1'b0;

    // CRC-32 (IEEE 802.3) preset
    localparam logic [63:0] CRC32_POLY    = 64'h04C1_1DB7;
    localparam logic [63:0] CRC32_INIT    = 64'hFFFF_FFFF;
    localparam logic [63:0] CRC32_XOR_OUT = 64'hFFFF_FFFF;
    localparam bit          CRC32_REFIN   = 1'b1;
    localparam bit          CRC32_REFOUT  = 1'b1;

    function automatic logic [7:0] reflect8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return r;
    endfunction

    // Reverses the low k bits of v; bits at and above k come back zero.
    function automatic logic [63:0] reflect_k(input logic [63:0] v, input int k);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < k) begin
                r[k-1-i] = v[i];
            end
        end
        return r;
    endfunction

    // Direct (non-augmented) CRC update over the low nb bits of 'bits',
    // most significant of those bits first. Widths are carried in 64-bit
    // containers and masked to k so one function serves every CRC width.
    function automatic logic [63:0] crc_step(input logic [63:0] rem, input logic [63:0] bits,
                                             input logic [63:0] poly, input int k, input int nb);
        logic [63:0] r;
        logic [63:0] mask;
        logic        fb;
        mask = (k >= 64) ? {64{1'b1}} : ((64'd1 << k) - 64'd1);
        r    = rem & mask;
        for (int i = 63; i >= 0; i--) begin
            if (i < nb) begin
                fb = r[k-1] ^ bits[i];
                r  = (r << 1) & mask;
                if (fb) begin
                    r = r ^ (poly & mask);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_stage.sv
// rtl/crc_stage.sv - one registered CRC pipeline stage consuming B message bits
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   en                  global pipeline advance
//   in_valid/out_valid  slot valid in / registered
//   in_rem/out_rem      running remainder in / registered after B bits
//   in_data/out_data    unconsumed message bits (top B bits consumed here)
//   in_tag/out_tag      sideband tag, passed through unchanged
module crc_stage
    import crc_pkg::*;
#(
    parameter int             K      = 8,
    parameter int             DW_IN  = 64,
    parameter int             B      = 8,
    parameter int             TAG_W  = 4,
    parameter logic [K-1:0]   POLY   = 8'h07,
    localparam int            DW_OUT = (DW_IN > B) ? DW_IN - B : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_valid,
    input  logic [K-1:0]      in_rem,
    input  logic [DW_IN-1:0]  in_data,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    output logic [K-1:0]      out_rem,
    output logic [DW_OUT-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag
);

    logic [K-1:0] next_rem;

    always_comb begin
        next_rem = K'(crc_step(64'(in_rem), 64'(in_data[DW_IN-1 -: B]), 64'(POLY), K, B));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_rem   <= '0;
            out_tag   <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_rem   <= next_rem;
            out_tag   <= in_tag;
        end
    end

    // The final stage consumes every remaining bit, so it carries no data.
    if (DW_IN > B) begin : g_data
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_data <= '0;
            end else if (en) begin
                out_data <= in_data[DW_IN-B-1:0];
            end
        end
    end else begin : g_no_data
        assign out_data = '0;
    end

endmodule

// File: rtl/crc_pipe_param.sv
// rtl/crc_pipe_param.sv - parametrised pipelined CRC generator, one word per clock
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid/in_ready        input handshake for msg/in_tag
//   msg [N-1:0]              message word, msg[N-1] first on the wire
//   in_tag [TAG_W-1:0]       opaque sideband returned with the result
//   out_valid/out_ready      output handshake for crc/out_tag
//   crc [K-1:0]              final CRC
//   out_tag [TAG_W-1:0]      tag of the word that produced crc
module crc_pipe_param
    import crc_pkg::*;
#(
    parameter int           K       = 8,
    parameter int           N       = 64,
    parameter int           B       = 8,
    parameter logic [K-1:0] POLY    = 8'h07,
    parameter logic [K-1:0] INIT    = '0,
    parameter logic [K-1:0] XOR_OUT = '0,
    parameter bit           REFIN   = 1'b0,
    parameter bit           REFOUT  = 1'b0,
    parameter int           TAG_W   = 4,
    localparam int          S       = N / B
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     msg,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [K-1:0]     crc,
    output logic [TAG_W-1:0] out_tag
);

    // One enable for the whole pipe: everything moves unless the result
    // register is full and not being taken. No in_valid term, so no
    // combinational in_valid -> in_ready path.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    logic [N-1:0] msg_r;

    always_comb begin
        msg_r = msg;
        if (REFIN) begin
            for (int j = 0; j < N / 8; j++) begin
                msg_r[8*j +: 8] = reflect8(msg[8*j +: 8]);
            end
        end
    end

    for (genvar gi = 0; gi < S; gi++) begin : g_stg
        localparam int DW_IN  = N - gi * B;
        localparam int DW_OUT = (DW_IN > B) ? DW_IN - B : 1;

        logic [DW_IN-1:0]  d_in;
        logic              v_in;
        logic [K-1:0]      r_in;
        logic [TAG_W-1:0]  t_in;
        logic [DW_OUT-1:0] d_out;
        logic              v_out;
        logic [K-1:0]      r_out;
        logic [TAG_W-1:0]  t_out;

        if (gi == 0) begin : g_head
            assign d_in = msg_r;
            assign v_in = in_valid;
            assign r_in = INIT;
            assign t_in = in_tag;
        end else begin : g_link
            assign d_in = g_stg[gi-1].d_out;
            assign v_in = g_stg[gi-1].v_out;
            assign r_in = g_stg[gi-1].r_out;
            assign t_in = g_stg[gi-1].t_out;
        end

        crc_stage #(
            .K     (K),
            .DW_IN (DW_IN),
            .B     (B),
            .TAG_W (TAG_W),
            .POLY  (POLY)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .in_valid  (v_in),
            .in_rem    (r_in),
            .in_data   (d_in),
            .in_tag    (t_in),
            .out_valid (v_out),
            .out_rem   (r_out),
            .out_data  (d_out),
            .out_tag   (t_out)
        );
    end

    logic             last_valid;
    logic [K-1:0]     last_rem;
    logic [TAG_W-1:0] last_tag;
    logic [K-1:0]     final_crc;

    assign last_valid = g_stg[S-1].v_out;
    assign last_rem   = g_stg[S-1].r_out;
    assign last_tag   = g_stg[S-1].t_out;

    always_comb begin
        final_crc = (REFOUT ? K'(reflect_k(64'(last_rem), K)) : last_rem) ^ XOR_OUT;
    end

    // crc/out_tag only load on a real result, so bubbles leave the last
    // value in place while out_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            crc       <= '0;
            out_tag   <= '0;
        end else if (en) begin
            out_valid <= last_valid;
            if (last_valid) begin
                crc     <= final_crc;
                out_tag <= last_tag;
            end
        end
    end

endmodule

// File: tb/tb_crc_pipe_param.sv
// tb/tb_crc_pipe_param.sv - directed self-checking bench for crc_pipe_param
module tb_crc_pipe_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // K=8, N=64, B=8, poly 07
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] msg = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  crc;
    logic [3:0]  out_tag;

    // CRC-8/SMBUS, N=72, B=4 (18 stages)
    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic [71:0] s_msg = '0;
    logic [3:0]  s_in_tag = '0;
    logic        s_out_valid;
    logic        s_out_ready = 1'b1;
    logic [7:0]  s_crc;
    logic [3:0]  s_out_tag;

    // CRC-32, N=72, B=8 (9 stages)
    logic        w_in_valid = 1'b0;
    logic        w_in_ready;
    logic [71:0] w_msg = '0;
    logic [3:0]  w_in_tag = '0;
    logic        w_out_valid;
    logic        w_out_ready = 1'b1;
    logic [31:0] w_crc;
    logic [3:0]  w_out_tag;

    crc_pipe_param #(.K(8), .N(64), .B(8), .POLY(8'h07), .INIT(8'h00), .XOR_OUT(8'h00),
                     .REFIN(1'b0), .REFOUT(1'b0), .TAG_W(4)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .msg(msg),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .crc(crc), .out_tag(out_tag));

    crc_pipe_param #(.K(8), .N(72), .B(4), .POLY(8'h07), .INIT(8'h00), .XOR_OUT(8'h00),
                     .REFIN(1'b0), .REFOUT(1'b0), .TAG_W(4)) u_smb (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .msg(s_msg),
        .in_tag(s_in_tag), .out_valid(s_out_valid), .out_ready(s_out_ready), .crc(s_crc),
        .out_tag(s_out_tag));

    crc_pipe_param #(.K(32), .N(72), .B(8), .POLY(32'h04C1_1DB7), .INIT(32'hFFFF_FFFF),
                     .XOR_OUT(32'hFFFF_FFFF), .REFIN(1'b1), .REFOUT(1'b1), .TAG_W(4)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready), .msg(w_msg),
        .in_tag(w_in_tag), .out_valid(w_out_valid), .out_ready(w_out_ready), .crc(w_crc),
        .out_tag(w_out_tag));

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_crc_q[$];
    logic [3:0] exp_tag_q[$];
    int         results;
    logic       stalled_prev = 1'b0;
    logic [7:0] prev_crc;
    logic [3:0] prev_tag;

    task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    // Bit-serial reference for CRC-8 poly 07, init 0, no reflection.
    function automatic logic [7:0] model_crc8(input logic [63:0] m);
        logic [7:0] r;
        logic       fb;
        r = 8'h00;
        for (int i = 63; i >= 0; i--) begin
            fb = r[7] ^ m[i];
            r  = {r[6:0], 1'b0};
            if (fb) r = r ^ 8'h07;
        end
        return r;
    endfunction

    // Entered and left at posedge+1 with the pipe empty and out_ready=1.
    task automatic run_single(input string nm, input logic [63:0] m, input logic [3:0] t,
                              input logic [7:0] exp_crc);
        int lat;
        msg      = m;
        in_tag   = t;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, "_latency"}, 64'(lat), 64'd8);
        check({nm, "_crc"}, 64'(crc), 64'(exp_crc));
        check({nm, "_tag"}, 64'(out_tag), 64'(t));
        @(posedge clk); #1;
        check({nm, "_valid_drop"}, 64'(out_valid), 64'd0);
    endtask

    // One streaming cycle, entered and left at posedge+1.
    task automatic cycle(input logic iv, input logic ordy);
        in_valid  = iv;
        out_ready = ordy;
        if (iv) begin
            msg    = {$urandom, $urandom};
            in_tag = 4'($urandom);
        end
        if (stalled_prev) begin
            check("stall_valid_hold", 64'(out_valid), 64'd1);
            check("stall_crc_hold", 64'(crc), 64'(prev_crc));
            check("stall_tag_hold", 64'(out_tag), 64'(prev_tag));
        end
        #1;
        if (out_valid && !out_ready) begin
            check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        if (out_valid && out_ready) begin
            if (exp_crc_q.size() == 0) begin
                check("unexpected_output", 64'd1, 64'd0);
            end else begin
                check("stream_crc", 64'(crc), 64'(exp_crc_q.pop_front()));
                check("stream_tag", 64'(out_tag), 64'(exp_tag_q.pop_front()));
            end
            results++;
        end
        if (in_valid && in_ready) begin
            exp_crc_q.push_back(model_crc8(msg));
            exp_tag_q.push_back(in_tag);
        end
        stalled_prev = out_valid && !out_ready;
        prev_crc     = crc;
        prev_tag     = out_tag;
        @(posedge clk); #1;
    endtask

    initial begin
        int lat_s;
        int lat_w;
        int guard;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_crc", 64'(crc), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_w_crc", 64'(w_crc), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Single words through the 64-bit pipe
        run_single("one", 64'h1, 4'h3, 8'h07);
        run_single("low80", 64'h80, 4'hA, 8'h89);
        run_single("zero", 64'h0, 4'h5, 8'h00);

        // "123456789" through CRC-8/SMBUS (B=4) and CRC-32 together
        s_msg       = 72'h31_3233_3435_3637_3839;
        w_msg       = 72'h31_3233_3435_3637_3839;
        s_in_tag    = 4'h6;
        w_in_tag    = 4'h9;
        s_in_valid  = 1'b1;
        w_in_valid  = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        w_in_valid = 1'b0;
        lat_s = 0;
        lat_w = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (s_out_valid && lat_s == 0) begin
                lat_s = c;
                check("smbus_crc", 64'(s_crc), 64'hF4);
                check("smbus_tag", 64'(s_out_tag), 64'h6);
            end
            if (w_out_valid && lat_w == 0) begin
                lat_w = c;
                check("crc32_crc", 64'(w_crc), 64'hCBF4_3926);
                check("crc32_tag", 64'(w_out_tag), 64'h9);
            end
        end
        check("smbus_latency", 64'(lat_s), 64'd18);
        check("crc32_latency", 64'(lat_w), 64'd9);

        // Back-to-back 100 words: word j shows up nine cycles after issue,
        // so all 100 must be out by the ninth drain cycle.
        results = 0;
        for (int i = 0; i < 100; i++) cycle(1'b1, 1'b1);
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1);
        check("b2b_count", 64'(results), 64'd100);
        check("b2b_queue_empty", 64'(exp_crc_q.size()), 64'd0);

        // Random flow control
        results = 0;
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)));
        end
        guard = 0;
        while (exp_crc_q.size() != 0 && guard < 200) begin
            cycle(1'b0, 1'b1);
            guard++;
        end
        check("rand_drained", 64'(exp_crc_q.size()), 64'd0);
        cycle(1'b0, 1'b1);
        check("rand_no_extra", 64'(out_valid), 64'd0);

        // Reset with five words in flight
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_crc", 64'(crc), 64'd0);
        check("midrst_out_tag", 64'(out_tag), 64'd0);
        exp_crc_q.delete();
        exp_tag_q.delete();
        stalled_prev = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_single("post_rst", 64'h80, 4'hC, 8'h89);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
